alu_op_sequencer: RTL and testbench

- Issuing side of the 32-bit ALU interface: accepts operation requests from a host over a valid/ready handshake and drives the ALU's sel/a/b inputs from registers.
- Holds those operands stable for the required number of cycles: 1 cycle for the combinational ops, MOD_CYCLES for the iterative mod op (sel=7).
- Captures the ALU result and returns it to the host over a second valid/ready handshake.
- Sits between the datapath control logic and the ALU instance.

---
 rtl/alu_op_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issue side of the 32-bit ALU: registers sel/a/b, holds them for the op's
// latency, captures the result and returns it over valid/ready. Optional perf counters: ALU_SEQ_PERF_EN.
module alu_op_sequencer #(
  parameter int MOD_CYCLES = 40,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [2:0]  alu_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        mod_clr,
  input  logic [31:0] alu_result,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_zero,
  output logic        resp_err
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0] op_count,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ready_q, req_ready_d;
  logic [2:0]         sel_q, sel_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               mod_clr_q, mod_clr_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rzero_q, rzero_d;
  logic               rerr_q, rerr_d;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0]        opcnt_q, opcnt_d;
  logic [7:0]         errcnt_q, errcnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    a_d       = a_q;
    b_d       = b_q;
    mod_clr_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rzero_d   = rzero_q;
    rerr_d    = rerr_q;
`ifdef ALU_SEQ_PERF_EN
    opcnt_d   = opcnt_q;
    errcnt_d  = errcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          if (req_op == 3'd7 && req_b == 32'd0) begin
            // Mod by zero never reaches the ALU; answer directly with an error.
            rdata_d  = 32'hFFFF_FFFF;
            rzero_d  = 1'b0;
            rerr_d   = 1'b1;
            rvalid_d = 1'b1;
            state_d  = RESP;
          end else begin
            sel_d     = req_op;
            a_d       = req_a;
            b_d       = req_b;
            cnt_d     = (req_op == 3'd7) ? CNT_W'(MOD_CYCLES) : CNT_W'(1);
            mod_clr_d = (req_op == 3'd7);
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rdata_d  = alu_result;
          rzero_d  = (alu_result == 32'd0);
          rerr_d   = 1'b0;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rvalid_q && resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
`ifdef ALU_SEQ_PERF_EN
          opcnt_d = opcnt_q + 16'd1;
          if (rerr_q && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready: low while busy and for the first cycle out of reset.
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      sel_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mod_clr_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rzero_q     <= 1'b0;
      rerr_q      <= 1'b0;
`ifdef ALU_SEQ_PERF_EN
      opcnt_q     <= '0;
      errcnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      sel_q       <= sel_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mod_clr_q   <= mod_clr_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rzero_q     <= rzero_d;
      rerr_q      <= rerr_d;
`ifdef ALU_SEQ_PERF_EN
      opcnt_q     <= opcnt_d;
      errcnt_q    <= errcnt_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign alu_sel    = sel_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign mod_clr    = mod_clr_q;
  assign resp_valid = rvalid_q;
  assign resp_data  = rdata_q;
  assign resp_zero  = rzero_q;
  assign resp_err   = rerr_q;
`ifdef ALU_SEQ_PERF_EN
  assign op_count   = opcnt_q;
  assign err_count  = errcnt_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: driver pushes expected responses at accept, monitor pops on each new response.
module tb_alu_op_sequencer;
  localparam int MC = 40;

  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [2:0]  alu_sel;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        mod_clr, resp_valid, resp_ready = 1'b0, resp_zero, resp_err;
  logic [31:0] resp_data;

  alu_op_sequencer #(.MOD_CYCLES(MC), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_sel(alu_sel),
    .alu_a(alu_a), .alu_b(alu_b), .mod_clr(mod_clr), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_err(resp_err));

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return (a < b) ? 32'd1 : 32'd0;
      3'd5: return a + b;
      3'd6: return a - b;
      default: return (b == 32'd0) ? 32'd0 : a % b;
    endcase
  endfunction

  // Stand-in ALU driven by the sequencer's registered operands.
  assign alu_result = alu_f(alu_sel, alu_a, alu_b);

  typedef struct {
    logic [31:0] data; logic zero; logic err; int lat; int acc; int nclr;
    logic [2:0] sel; logic [31:0] a; logic [31:0] b;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0, n_err = 0, cyc = 0;
  logic [2:0]  m_sel = '0;
  logic [31:0] m_a = '0, m_b = '0;
  logic        rr_force = 1'b1, rr_val = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    t = 0;
    while (!req_ready && t < 1000) begin @(negedge clk); t++; end
    if (!req_ready) chk("accept_timeout", 64'(req_ready), 64'd1);
    else begin
      e.acc = cyc + 1;
      if (op == 3'd7 && b == 32'd0) begin
        e.data = 32'hFFFF_FFFF; e.zero = 1'b0; e.err = 1'b1; e.lat = 0; e.nclr = 0;
      end else begin
        e.data = alu_f(op, a, b); e.zero = (e.data == 32'd0); e.err = 1'b0;
        e.lat  = (op == 3'd7) ? MC : 1; e.nclr = (op == 3'd7) ? 1 : 0;
        m_sel = op; m_a = a; m_b = b;
      end
      e.sel = m_sel; e.a = m_a; e.b = m_b;
      q.push_back(e);
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() > 0 && t < 3000) begin @(negedge clk); t++; end
    chk("drain", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial forever begin
    @(negedge clk);
    resp_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
  end

  // Monitor: sampled 1 time unit after each rising edge.
  initial begin
    logic        p_valid, p_zero, p_err, p_rdy;
    logic [31:0] p_data, p_a, p_b;
    logic [2:0]  p_sel;
    int          nclr;
    exp_t        e;
    p_valid = 0; p_zero = 0; p_err = 0; p_rdy = 0; p_data = 0; p_a = 0; p_b = 0; p_sel = 0; nclr = 0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        if (mod_clr) nclr++;
        if (p_valid && !resp_ready) begin
          chk("hold_data", 64'(resp_data), 64'(p_data));
          chk("hold_flags", {61'd0, resp_valid, resp_zero, resp_err}, {61'd0, 1'b1, p_zero, p_err});
        end else if (p_valid && resp_ready) begin
          chk("resp_release", 64'(resp_valid), 64'd0);
        end
        if (!p_rdy) begin
          chk("alu_stable_sa", {29'd0, alu_sel, alu_a}, {29'd0, p_sel, p_a});
          chk("alu_stable_b", 64'(alu_b), 64'(p_b));
        end
        if (resp_valid && !p_valid) begin
          if (q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            chk("resp_data", 64'(resp_data), 64'(e.data));
            chk("resp_zero_err", {62'd0, resp_zero, resp_err}, {62'd0, e.zero, e.err});
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            chk("mod_clr_pulses", 64'(nclr), 64'(e.nclr));
            chk("alu_regs", {29'd0, alu_sel, alu_a}, {29'd0, e.sel, e.a});
            chk("alu_b_reg", 64'(alu_b), 64'(e.b));
          end
          nclr = 0;
        end
      end else nclr = 0;
      p_valid = reset ? 1'b0 : resp_valid;
      p_data = resp_data; p_zero = resp_zero; p_err = resp_err;
      p_rdy = reset ? 1'b1 : req_ready;
      p_sel = alu_sel; p_a = alu_a; p_b = alu_b;
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {57'd0, req_ready, alu_sel, mod_clr, resp_valid, resp_zero},
        64'd0);
    chk("rst_ab", {alu_a, alu_b}, 64'd0);
    chk("rst_resp", {31'd0, resp_err, resp_data}, 64'd0);
    reset = 1'b0;
    #1 chk("ready_before_edge", 64'(req_ready), 64'd0);
    @(posedge clk); #1 chk("ready_after_edge", 64'(req_ready), 64'd1);

    // Directed cases
    issue(3'd5, 32'd5, 32'd7);
    issue(3'd6, 32'd3, 32'd5);
    issue(3'd6, 32'd9, 32'd9);
    issue(3'd7, 32'd17, 32'd5);
    issue(3'd7, 32'd100, 32'd0);
    wait_drain();

    // Backpressure: second request offered while the first response is stalled
    rr_val = 1'b0;
    issue(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    req_valid = 1'b1; req_op = 3'd2; req_a = 32'h1234_5678; req_b = 32'h0F0F_0F0F;
    repeat (4) begin @(negedge clk); chk("busy_not_ready", 64'(req_ready), 64'd0); end
    rr_val = 1'b1;
    issue(3'd2, 32'h1234_5678, 32'h0F0F_0F0F);
    wait_drain();

    // Random traffic with random response backpressure
    rr_force = 1'b0;
    repeat (50) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom; b = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(0, 9)); end
        default: ;
      endcase
      if (op == 3'd7 && $urandom_range(0, 2) == 0) b = 32'd0;
      issue(op, a, b);
    end
    wait_drain();

    // Reset in the middle of a mod op
    rr_force = 1'b1; rr_val = 1'b1;
    issue(3'd7, 32'd17, 32'd5);
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ctrl", {57'd0, req_ready, alu_sel, mod_clr, resp_valid, resp_zero}, 64'd0);
    chk("midrst_ab", {alu_a, alu_b}, 64'd0);
    chk("midrst_resp", {31'd0, resp_err, resp_data}, 64'd0);
    q.delete();
    m_sel = '0; m_a = '0; m_b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("midrst_ready_before", 64'(req_ready), 64'd0);
    @(posedge clk); #1 chk("midrst_ready_after", 64'(req_ready), 64'd1);
    issue(3'd1, 32'd1, 32'd2);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
